// File: rtl/fp_adder_pkg.sv
// Shared binary32 format constants, the fp32_t view of a word and classification helpers.
package fp_adder_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRAC_W  = 23;
   localparam int unsigned BIAS    = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   function automatic logic is_nan(input fp32_t x);
      return (x.exp == EXP_MAX) && (x.frac != '0);
   endfunction

   function automatic logic is_inf(input fp32_t x);
      return (x.exp == EXP_MAX) && (x.frac == '0);
   endfunction

   // Denormals count as zero: the fraction is ignored whenever exp is 0.
   function automatic logic is_zero(input fp32_t x);
      return x.exp == '0;
   endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational binary32 add: unpack, align, add/sub, normalise, round-to-nearest-even, pack.
module fp_add_core
   import fp_adder_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   function automatic logic [4:0] count_lz(input logic [26:0] v);
      logic [4:0] n;
      logic       done;
      n    = '0;
      done = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!done) begin
            if (v[i]) done = 1'b1;
            else      n    = n + 5'd1;
         end
      end
      return n;
   endfunction

   fp32_t              fa, fb, fl, fs;
   logic               a_ge_b;
   logic [EXP_W-1:0]   exp_diff;
   logic [23:0]        mant_l, mant_s;
   logic [49:0]        shift_full;
   logic [25:0]        aligned;
   logic               sticky;
   logic [27:0]        raw_sum;
   logic [4:0]         lzc;
   logic [26:0]        norm;
   logic signed [9:0]  exp_n, exp_r;
   logic               round_up;
   logic [24:0]        rounded;
   logic [FRAC_W-1:0]  frac_r;
   logic [31:0]        normal_res;

   assign fa = a;
   assign fb = b;

   always_comb begin
      a_ge_b   = {fa.exp, fa.frac} >= {fb.exp, fb.frac};
      fl       = a_ge_b ? fa : fb;
      fs       = a_ge_b ? fb : fa;
      mant_l   = {1'b1, fl.frac};
      mant_s   = {1'b1, fs.frac};
      exp_diff = fl.exp - fs.exp;

      // Layout below the 24-bit mantissa: guard, round, sticky.
      shift_full = {mant_s, 26'b0} >> exp_diff;
      if (exp_diff >= 8'd26) begin
         aligned = '0;
         sticky  = 1'b1;
      end else begin
         aligned = shift_full[49:24];
         sticky  = |shift_full[23:0];
      end

      if (fl.sign == fs.sign)
         raw_sum = {1'b0, mant_l, 3'b000} + {1'b0, aligned, sticky};
      else
         raw_sum = {1'b0, mant_l, 3'b000} - {1'b0, aligned, sticky};

      lzc = count_lz(raw_sum[26:0]);
      if (raw_sum[27]) begin
         norm  = {raw_sum[27:2], raw_sum[1] | raw_sum[0]};
         exp_n = $signed({2'b00, fl.exp}) + 10'sd1;
      end else begin
         norm  = raw_sum[26:0] << lzc;
         exp_n = $signed({2'b00, fl.exp}) - $signed({5'b00000, lzc});
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rounded  = {1'b0, norm[26:3]} + {24'b0, round_up};
      if (rounded[24]) begin
         exp_r  = exp_n + 10'sd1;
         frac_r = rounded[23:1];
      end else begin
         exp_r  = exp_n;
         frac_r = rounded[22:0];
      end

      // Exact cancellation always yields +0.
      if (raw_sum == '0)
         normal_res = 32'h0000_0000;
      else if (exp_r >= 10'sd255)
         normal_res = {fl.sign, EXP_MAX, 23'b0};
      else if (exp_r <= 10'sd0)
         normal_res = {fl.sign, 31'b0};
      else
         normal_res = {fl.sign, exp_r[7:0], frac_r};

      if (is_nan(fa) || is_nan(fb))
         sum = QNAN;
      else if (is_inf(fa) && is_inf(fb) && (fa.sign != fb.sign))
         sum = QNAN;
      else if (is_inf(fa))
         sum = a;
      else if (is_inf(fb))
         sum = b;
      else if (is_zero(fa) && is_zero(fb))
         sum = {fa.sign & fb.sign, 31'b0};
      else if (is_zero(fb))
         sum = a;
      else if (is_zero(fa))
         sum = b;
      else
         sum = normal_res;
   end

endmodule

// File: rtl/fp_adder_single_cycle.sv
// Binary32 adder with a single registered output; sum follows the operands by one clock.
module fp_adder_single_cycle
   import fp_adder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   fp32_t next_sum;

   fp_add_core u_core (
      .a   (a),
      .b   (b),
      .sum (next_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum <= 32'h0000_0000;
      else        sum <= next_sum;
   end

endmodule

// File: tb/tb_fp_adder_single_cycle.sv
// Directed-vector bench for fp_adder_single_cycle with hand-computed binary32 results.
module tb_fp_adder_single_cycle;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b;
   logic [31:0] sum;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   vec_t vecs[$];

   fp_adder_single_cycle dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .sum   (sum)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic add_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ve);
      vec_t v;
      v.name = name; v.a = va; v.b = vb; v.exp = ve;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      a = va;
      b = vb;
   endtask

   initial begin
      add_vec("sub_99_89",      32'h42C60000, 32'hC2B20000, 32'h41200000);
      add_vec("sub_m45_79",     32'hC2340000, 32'h429E0000, 32'h42080000);
      add_vec("add_m283_m66",   32'hC38D8000, 32'hC2840000, 32'hC3AE8000);
      add_vec("sub_frac_neg",   32'hC2DC4000, 32'h42C7C000, 32'hC1240000);
      add_vec("add_frac",       32'h42DDC000, 32'h42C64000, 32'h43520000);
      add_vec("zero_pp",        32'h00000000, 32'h00000000, 32'h00000000);
      add_vec("zero_plus_x",    32'h00000000, 32'hC2EA0000, 32'hC2EA0000);
      add_vec("x_plus_mzero",   32'h42C40000, 32'h80000000, 32'h42C40000);
      add_vec("cancel",         32'h3F800000, 32'hBF800000, 32'h00000000);
      add_vec("zero_mm",        32'h80000000, 32'h80000000, 32'h80000000);
      add_vec("zero_pm",        32'h00000000, 32'h80000000, 32'h00000000);
      add_vec("denorm_flush",   32'h00000001, 32'h3F800000, 32'h3F800000);
      add_vec("rne_tie_even",   32'h3F800000, 32'h33800000, 32'h3F800000);
      add_vec("rne_above_tie",  32'h3F800000, 32'h33800001, 32'h3F800001);
      add_vec("rne_tie_odd",    32'h3F800001, 32'h33800000, 32'h3F800002);
      add_vec("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      add_vec("inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000);
      add_vec("nan_in",         32'h7FC00001, 32'h3F800000, 32'h7FC00000);
      add_vec("neg_inf",        32'hFF800000, 32'h42C40000, 32'hFF800000);
      add_vec("far_shift",      32'h4B800000, 32'h3F800000, 32'h4B800000);
      add_vec("add_1_1",        32'h3F800000, 32'h3F800000, 32'h40000000);

      // Reset acts before any clock edge, with live operands applied.
      rst_n = 1'b1;
      a = 32'h42C40000;
      b = 32'h43290000;
      #1 rst_n = 1'b0;
      #1 check("reset_async", sum, 32'h00000000);
      @(posedge clk); #1 check("reset_hold", sum, 32'h00000000);

      @(negedge clk);
      rst_n = 1'b1;
      a = 32'h42C40000;
      b = 32'h43290000;
      @(posedge clk); #1 check("first_after_reset", sum, 32'h43858000);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].a, vecs[i].b);
         @(posedge clk); #1 check(vecs[i].name, sum, vecs[i].exp);
      end

      // Back-to-back operands in random order; each edge must reflect the previous sample.
      for (int n = 0; n < 24; n++) begin
         int idx;
         idx = $urandom_range(0, vecs.size() - 1);
         apply(vecs[idx].a, vecs[idx].b);
         exp_q.push_back(vecs[idx].exp);
         @(posedge clk); #1;
         check($sformatf("pipe_%0d_%s", n, vecs[idx].name), sum, exp_q.pop_front());
      end

      apply(32'h42C60000, 32'hC2B20000);
      #2 rst_n = 1'b0;
      #1 check("mid_reset_async", sum, 32'h00000000);
      @(posedge clk); #1 check("mid_reset_hold", sum, 32'h00000000);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 check("after_mid_reset", sum, 32'h41200000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
